// File: rtl/sha1_block_engine.sv
// sha1_block_engine: chained SHA-1 compression of 512-bit blocks, UNROLL rounds per clock
module sha1_block_engine #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] block_in,
  input  logic         block_first,
  input  logic         block_valid,
  output logic         block_ready,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         busy
);
  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5)) begin : g_bad
    $error("UNROLL must be 1, 2, 4 or 5");
  end
  typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;
  state_t state_q, state_d;
  logic [6:0] t_q, t_d;
  logic [15:0][31:0] w_q, w_d;
  logic [4:0][31:0] v_q, v_d, h_q, h_d;
  logic [159:0] digest_q, digest_d;
  logic [31:0] x [0:15+UNROLL];
  logic [UNROLL:0][4:0][31:0] s;
  logic [1:0] ph;
  logic accept;
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction
  function automatic logic [159:0] step(input logic [159:0] v, input logic [31:0] w, input logic [1:0] p);
    logic [31:0] a, b, c, d, e, f, k;
    {a, b, c, d, e} = v;
    f = p == 2'd0 ? (b & c) | (~b & d) : p == 2'd2 ? (b & c) | (b & d) | (c & d) : b ^ c ^ d;
    k = p == 2'd0 ? 32'h5a827999 : p == 2'd1 ? 32'h6ed9eba1 : p == 2'd2 ? 32'h8f1bbcdc : 32'hca62c1d6;
    return {rotl(a, 5) + f + e + k + w, a, rotl(b, 30), c, d};
  endfunction
  assign ph = t_q < 7'd20 ? 2'd0 : t_q < 7'd40 ? 2'd1 : t_q < 7'd60 ? 2'd2 : 2'd3;
  assign accept = block_valid && block_ready;
  assign digest = digest_q;
  // x holds the window extended by the UNROLL words the schedule needs next
  always_comb begin
    for (int i = 0; i < 16; i++) x[i] = w_q[i];
    for (int i = 0; i < UNROLL; i++) x[16+i] = rotl(x[13+i] ^ x[8+i] ^ x[2+i] ^ x[i], 1);
    s[0] = v_q;
    for (int i = 0; i < UNROLL; i++) s[i+1] = step(s[i], x[i], ph);
  end
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    if (accept) state_d = ROUND;
    else if (state_q == ROUND && t_q == 7'(80 - UNROLL)) state_d = ADD;
    else if (state_q == ADD) state_d = DONE;
  end
  always_comb begin
    block_ready  = state_q == IDLE || state_q == DONE;
    busy         = state_q == ROUND || state_q == ADD;
    digest_valid = state_q == DONE;
  end
  always_comb begin
    w_d = w_q;
    v_d = v_q;
    h_d = h_q;
    t_d = t_q;
    digest_d = digest_q;
    if (accept) begin
      h_d = block_first ? IV : h_q;
      v_d = h_d;
      for (int i = 0; i < 16; i++) w_d[i] = block_in[511-32*i -: 32];
      t_d = '0;
    end else if (state_q == ROUND) begin
      v_d = s[UNROLL];
      for (int i = 0; i < 16; i++) w_d[i] = x[i+UNROLL];
      t_d = t_q + 7'(UNROLL);
    end else if (state_q == ADD) begin
      for (int i = 0; i < 5; i++) h_d[i] = h_q[i] + v_q[i];
      digest_d = h_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q <= '0;
      v_q <= '0;
      h_q <= IV;
      t_q <= '0;
      digest_q <= IV;
    end else begin
      w_q <= w_d;
      v_q <= v_d;
      h_q <= h_d;
      t_q <= t_d;
      digest_q <= digest_d;
    end
  end
endmodule

// File: doc/sha1_block_engine.md
# sha1_block_engine

Parametrised SHA-1 compression engine: second-generation successor to the single-block `sha1` core. It accepts 512-bit padded message blocks over a valid/ready handshake and computes the full 80-round compression with the rolling message schedule. Multi-block messages are supported by chaining the hash state across blocks. A parameter selects 1, 2, 4 or 5 rounds per clock. It sits between the padding/framing logic upstream and the digest consumer downstream.

## Interface
- `UNROLL`, default 1: SHA-1 rounds computed per clock. Legal values are 1, 2, 4, 5. Any other value is an elaboration error.
- `clk` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `block_in` in 512: padded message block, word 0 = `block_in[511:480]`, big-endian.
- `block_first` in 1: sampled with the block. 1 = start a new message, so the chaining state is loaded with the IV. 0 = continue from the current H.
- `block_valid` in 1: a block is offered.
- `block_ready` out 1: engine can accept a block.
- `digest` out 160: {H0,H1,H2,H3,H4}, registered.
- `digest_valid` out 1: `digest` holds the result of the last accepted block.
- `busy` out 1: a compression is in progress.

## Operation
- States:
  - IDLE: `block_ready`=1.
  - ROUND: `busy`=1.
  - ADD: `busy`=1.
  - DONE: `block_ready`=1, `digest_valid`=1.
- Handshake: a block is accepted in a cycle where `block_valid` && `block_ready`. From IDLE or DONE the engine then goes to ROUND.
- On accept:
  - Latch the 16 words into the schedule window.
  - If `block_first`=1, H0..H4 are set to the IV 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0.
  - Load a..e from the (possibly reloaded) H.
  - Clear the round counter t.
- Schedule:
  - For t<16, W[t] = word t.
  - For t≥16, W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
  - The window is a 16×32 shift structure that advances UNROLL words per cycle.
- Round function, all arithmetic mod 2^32:
  - temp = rotl5(a)+f+e+K+W[t].
  - Then e=d, d=c, c=rotl30(b), b=a, a=temp.
  - True rotations, not shifts.
- f and K by round:
  - t 0–19: f=(b&c)|(~b&d) (bitwise NOT), K=5A827999.
  - t 20–39: f=b^c^d, K=6ED9EBA1.
  - t 40–59: f=(b&c)|(b&d)|(c&d), K=8F1BBCDC.
  - t 60–79: f=b^c^d, K=CA62C1D6.
- With UNROLL>1, each cycle chains UNROLL rounds combinationally. Because UNROLL divides 20, a cycle never straddles a K/f boundary.
- ROUND → ADD after round 79 completes.
- ADD: Hi <= Hi + {a..e}i, then → DONE.
- DONE:
  - Holds `digest` stable until the next block is accepted.
  - Accepting a block in DONE clears `digest_valid` on the next cycle.
- `block_valid` while `busy` is ignored; `block_in` is not sampled.
- `block_first`=0 immediately after reset chains from the IV, because H resets to IV.

## Timing
- Reset values:
  - state IDLE.
  - `block_ready`=1 from the first cycle after reset is released.
  - `digest_valid`=0, `busy`=0.
  - `digest` = IV concatenation.
  - a..e and the window are cleared to 0.
- Let R = 80/UNROLL. Accept occurs at cycle T.
  - Cycles T+1..T+R: ROUND.
  - T+R+1: ADD.
  - `digest_valid`=1 and the new `digest` are visible at T+R+2.
- Latency from accept to `digest_valid`: R+2 cycles. That is 82 for UNROLL=1 and 18 for UNROLL=5.
- Back-to-back: a block accepted in the first DONE cycle starts the next compression. Throughput is one block per R+2 cycles.
- Reset mid-operation:
  - Aborts immediately and returns to IDLE.
  - H returns to IV, `digest_valid`=0.
  - No partial result is ever exposed on `digest`.
- Reset and `block_valid` in the same cycle: reset wins and the block is not accepted.

## Test plan
- "abc" block 61626380_00…00_00000018, `block_first`=1, UNROLL=1 → `digest`=a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, with `digest_valid` rising exactly 82 cycles after accept.
- Empty message block 80000000_00…00 → da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709. Repeat for UNROLL=2, 4, 5 and check latency is 42, 22, 18 respectively.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": first block with `block_first`=1, second with `block_first`=0 accepted in the first DONE cycle → 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
- Hold `block_valid` high with changing `block_in` during ROUND → `block_ready`=0 and the result is unaffected. A new "abc" block with `block_first`=1 after a completed message → the "abc" digest, with no chaining leak.
- Assert `reset` for 1 cycle at round 40 → next cycle IDLE, `digest`=IV, `digest_valid`=0. A following "abc" block yields the correct digest.
- Reset asserted in the same cycle as `block_valid`=1 → no accept. `busy` stays 0.
